config_self_write_bridge: RTL and testbench

//  Buffers 32-bit configuration words from an on-chip CPU bus into a FIFO.

---
 rtl/config_self_write_bridge.sv | 128 ++++++++++++
 tb/tb_config_self_write_bridge.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/config_self_write_bridge.sv
// Buffers CPU configuration words in a FIFO and replays them as paced
// single-cycle strobes on the config block's self-write port.
module config_self_write_bridge #(
    parameter int FIFO_DEPTH = 8,
    parameter int FIFO_AW    = 3,
    parameter int STROBE_GAP = 2
) (
    input  logic               CLK,
    input  logic               Reset,
    input  logic [31:0]        BusWriteData,
    input  logic               BusWriteValid,
    output logic               BusWriteReady,
    input  logic               Flush,
    input  logic               Hold,
    output logic [31:0]        SelfWriteData,
    output logic               SelfWriteStrobe,
    output logic [FIFO_AW:0]   Level,
    output logic               Busy,
    output logic [31:0]        WordCount
);

    localparam int GW = (STROBE_GAP > 1) ? $clog2(STROBE_GAP) : 1;
    localparam logic [FIFO_AW:0] FULL = (FIFO_AW+1)'(FIFO_DEPTH);
    localparam logic [FIFO_AW:0] ONE  = (FIFO_AW+1)'(1);
    localparam logic [GW-1:0] GAP_LOAD = GW'(STROBE_GAP - 1);

    typedef enum logic [1:0] {
        IDLE,
        STROBE,
        GAP
    } state_t;

    state_t state;
    state_t state_next;

    logic [31:0]        mem [FIFO_DEPTH];
    logic [FIFO_AW-1:0] wr_ptr;
    logic [FIFO_AW-1:0] rd_ptr;
    logic [FIFO_AW:0]   level_next;
    logic [GW-1:0]      gap_cnt;
    logic [GW-1:0]      gap_next;
    logic [31:0]        wcount;
    logic               push;
    logic               pop;

    assign BusWriteReady = !Reset && !Flush && (Level != FULL);
    assign push          = BusWriteValid && BusWriteReady;
    assign Busy          = (Level != '0) || (state != IDLE);
    assign WordCount     = wcount;

    always_comb begin
        unique case ({push, pop})
            2'b10:   level_next = Level + ONE;
            2'b01:   level_next = Level - ONE;
            default: level_next = Level;
        endcase
    end

    always_comb begin
        state_next = state;
        gap_next   = gap_cnt;
        pop        = 1'b0;
        unique case (state)
            IDLE: begin
                // Hold only gates new strobes; a strobe already issued finishes.
                if (Level != '0 && !Hold && !Flush) begin
                    pop        = 1'b1;
                    state_next = STROBE;
                end
            end
            STROBE: begin
                state_next = GAP;
                gap_next   = GAP_LOAD;
            end
            GAP: begin
                if (gap_cnt == '0) begin
                    state_next = IDLE;
                end else begin
                    gap_next = gap_cnt - GW'(1);
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (push) begin
            mem[wr_ptr] <= BusWriteData;
        end
    end

    always_ff @(posedge CLK) begin
        if (Reset) begin
            state           <= IDLE;
            gap_cnt         <= '0;
            wr_ptr          <= '0;
            rd_ptr          <= '0;
            Level           <= '0;
            SelfWriteStrobe <= 1'b0;
            SelfWriteData   <= '0;
            wcount          <= '0;
        end else begin
            state           <= state_next;
            gap_cnt         <= gap_next;
            SelfWriteStrobe <= pop;
            if (pop) begin
                SelfWriteData <= mem[rd_ptr];
            end
            if (state == STROBE) begin
                wcount <= wcount + 32'd1;
            end
            if (Flush) begin
                wr_ptr <= '0;
                rd_ptr <= '0;
                Level  <= '0;
            end else begin
                if (push) begin
                    wr_ptr <= wr_ptr + FIFO_AW'(1);
                end
                if (pop) begin
                    rd_ptr <= rd_ptr + FIFO_AW'(1);
                end
                Level <= level_next;
            end
        end
    end

endmodule

// File: tb/tb_config_self_write_bridge.sv
// Directed bench for config_self_write_bridge with an in-order
// scoreboard of accepted words and a model of the strobe counter.
module tb_config_self_write_bridge;

    logic        CLK;
    logic        Reset;
    logic [31:0] BusWriteData;
    logic        BusWriteValid;
    logic        BusWriteReady;
    logic        Flush;
    logic        Hold;
    logic [31:0] SelfWriteData;
    logic        SelfWriteStrobe;
    logic [3:0]  Level;
    logic        Busy;
    logic [31:0] WordCount;

    config_self_write_bridge #(
        .FIFO_DEPTH(8),
        .FIFO_AW(3),
        .STROBE_GAP(2)
    ) dut (
        .CLK(CLK),
        .Reset(Reset),
        .BusWriteData(BusWriteData),
        .BusWriteValid(BusWriteValid),
        .BusWriteReady(BusWriteReady),
        .Flush(Flush),
        .Hold(Hold),
        .SelfWriteData(SelfWriteData),
        .SelfWriteStrobe(SelfWriteStrobe),
        .Level(Level),
        .Busy(Busy),
        .WordCount(WordCount)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    int          pass_cnt = 0;
    int          total    = 0;
    int          cyc      = 0;
    int          n_strobes = 0;
    int          max_level = 0;
    logic        acc_last = 1'b0;
    logic        prev_strobe = 1'b0;
    logic [31:0] exp_wc = '0;
    logic [31:0] expq [$];
    int          strobe_t [$];

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        total++;
        if (got === exp) begin
            pass_cnt++;
        end else begin
            $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)",
                     tag, got, exp, $time);
        end
    endtask

    // One clock: samples the handshake before the edge, updates the model,
    // then checks strobes and WordCount 1ns after the edge.
    task automatic tick();
        logic        acc;
        logic        fl;
        logic        rs;
        logic [31:0] d;
        acc = BusWriteValid && BusWriteReady;
        fl  = Flush;
        rs  = Reset;
        d   = BusWriteData;
        @(posedge CLK);
        #1;
        cyc++;
        acc_last = acc;
        if (rs) begin
            expq.delete();
            exp_wc      = '0;
            prev_strobe = 1'b0;
        end else begin
            if (prev_strobe) exp_wc = exp_wc + 32'd1;
            if (fl) expq.delete();
            if (acc) expq.push_back(d);
            prev_strobe = SelfWriteStrobe;
            if (SelfWriteStrobe) begin
                n_strobes++;
                strobe_t.push_back(cyc);
                if (expq.size() == 0)
                    check("strobe_unexpected", 32'(SelfWriteStrobe), 32'd0);
                else
                    check("strobe_data", SelfWriteData, expq.pop_front());
            end
        end
        check("word_count", WordCount, exp_wc);
        if (int'(Level) > max_level) max_level = int'(Level);
    endtask

    initial begin
        int s0;
        int i0;
        int nxt;
        Reset         = 1'b1;
        BusWriteData  = '0;
        BusWriteValid = 1'b0;
        Flush         = 1'b0;
        Hold          = 1'b0;
        #1;
        check("ready_in_reset", 32'(BusWriteReady), 32'd0);
        tick();
        tick();
        Reset = 1'b0;
        #1;
        check("rst_level", 32'(Level), 32'd0);
        check("rst_strobe", 32'(SelfWriteStrobe), 32'd0);
        check("rst_data", SelfWriteData, 32'd0);
        check("rst_busy", 32'(Busy), 32'd0);
        check("rst_ready", 32'(BusWriteReady), 32'd1);

        // single word latency
        BusWriteValid = 1'b1;
        BusWriteData  = 32'hDEAD_BEEF;
        tick();
        BusWriteValid = 1'b0;
        check("t1_level_e0", 32'(Level), 32'd1);
        check("t1_strobe_e0", 32'(SelfWriteStrobe), 32'd0);
        tick();
        check("t1_strobe_e1", 32'(SelfWriteStrobe), 32'd1);
        check("t1_data_e1", SelfWriteData, 32'hDEAD_BEEF);
        tick();
        check("t1_strobe_e2", 32'(SelfWriteStrobe), 32'd0);
        check("t1_wc_e2", WordCount, 32'd1);
        check("t1_data_hold", SelfWriteData, 32'hDEAD_BEEF);
        tick();
        check("t1_busy_e3", 32'(Busy), 32'd1);
        tick();
        check("t1_busy_e4", 32'(Busy), 32'd0);

        // hold while filling, then drain at full rate
        Hold = 1'b1;
        for (int i = 0; i < 8; i++) begin
            BusWriteValid = 1'b1;
            BusWriteData  = 32'h100 + 32'(i);
            tick();
        end
        BusWriteData = 32'h999;
        #1;
        check("t2_level_full", 32'(Level), 32'd8);
        check("t2_ready_full", 32'(BusWriteReady), 32'd0);
        s0 = n_strobes;
        for (int i = 0; i < 3; i++) tick();
        check("t2_no_strobe_hold", 32'(n_strobes), 32'(s0));
        check("t2_still_full", 32'(Level), 32'd8);
        Hold = 1'b0;
        i0 = strobe_t.size();
        for (int i = 0; i < 60; i++) begin
            tick();
            if (acc_last) BusWriteValid = 1'b0;
        end
        check("t2_strobe_count", 32'(n_strobes - s0), 32'd9);
        check("t2_valid_dropped", 32'(BusWriteValid), 32'd0);
        if (strobe_t.size() >= i0 + 9) begin
            for (int k = i0 + 1; k < i0 + 9; k++)
                check("t2_period", 32'(strobe_t[k] - strobe_t[k-1]), 32'd4);
        end
        check("t2_idle", 32'(Busy), 32'd0);

        // continuous valid with counter data
        s0  = n_strobes;
        nxt = 1;
        max_level = 0;
        BusWriteValid = 1'b1;
        for (int i = 0; i < 300 && nxt <= 20; i++) begin
            BusWriteData = 32'(nxt);
            tick();
            if (acc_last) nxt++;
        end
        BusWriteValid = 1'b0;
        check("t3_all_sent", 32'(nxt), 32'd21);
        for (int i = 0; i < 40; i++) tick();
        check("t3_strobes", 32'(n_strobes - s0), 32'd20);
        check("t3_q_empty", 32'(expq.size()), 32'd0);
        check("t3_max_level_ok", 32'(max_level <= 8), 32'd1);

        // flush with a strobe in flight
        Hold = 1'b1;
        for (int i = 0; i < 6; i++) begin
            BusWriteValid = 1'b1;
            BusWriteData  = 32'h400 + 32'(i);
            tick();
        end
        BusWriteValid = 1'b0;
        Hold = 1'b0;
        s0 = n_strobes;
        tick();
        check("t4_strobe", 32'(SelfWriteStrobe), 32'd1);
        check("t4_level5", 32'(Level), 32'd5);
        Hold          = 1'b1;
        Flush         = 1'b1;
        BusWriteValid = 1'b1;
        BusWriteData  = 32'hBAD;
        #1;
        check("t4_ready_flush", 32'(BusWriteReady), 32'd0);
        tick();
        Flush         = 1'b0;
        BusWriteValid = 1'b0;
        check("t4_level0", 32'(Level), 32'd0);
        check("t4_strobe_low", 32'(SelfWriteStrobe), 32'd0);
        Hold = 1'b0;
        for (int i = 0; i < 6; i++) tick();
        check("t4_one_strobe", 32'(n_strobes - s0), 32'd1);
        check("t4_busy", 32'(Busy), 32'd0);

        // reset during GAP
        Hold = 1'b1;
        for (int i = 0; i < 4; i++) begin
            BusWriteValid = 1'b1;
            BusWriteData  = 32'h500 + 32'(i);
            tick();
        end
        BusWriteValid = 1'b0;
        Hold = 1'b0;
        tick();
        Hold = 1'b1;
        tick();
        check("t5_level3", 32'(Level), 32'd3);
        check("t5_busy", 32'(Busy), 32'd1);
        Reset = 1'b1;
        #1;
        check("t5_ready_rst", 32'(BusWriteReady), 32'd0);
        tick();
        check("t5_strobe", 32'(SelfWriteStrobe), 32'd0);
        check("t5_level", 32'(Level), 32'd0);
        check("t5_wc", WordCount, 32'd0);
        Reset = 1'b0;
        Hold  = 1'b0;
        #1;
        check("t5_ready_after", 32'(BusWriteReady), 32'd1);
        s0 = n_strobes;
        for (int i = 0; i < 5; i++) tick();
        check("t5_no_strobe", 32'(n_strobes - s0), 32'd0);

        // WordCount wrap
        force dut.wcount = 32'hFFFF_FFFF;
        #1;
        release dut.wcount;
        exp_wc = 32'hFFFF_FFFF;
        check("t6_preload", WordCount, 32'hFFFF_FFFF);
        BusWriteValid = 1'b1;
        BusWriteData  = 32'h600;
        tick();
        BusWriteValid = 1'b0;
        for (int i = 0; i < 5; i++) tick();
        check("t6_wrap", WordCount, 32'd0);

        $display("%0d/%0d checks passed", pass_cnt, total);
        $finish;
    end

endmodule
